// File: rtl/core_mem_responder_pkg.sv
// Shared widths and enums for the core memory responder.
package pkg_opengpu;
  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int INSTR_WIDTH = 32;

  typedef enum logic [1:0] {MR_IDLE, MR_WAIT, MR_RESP} mem_resp_state_e;
  typedef enum logic {PORT_IMEM, PORT_DMEM} mem_port_e;
endpackage

// File: rtl/core_mem_responder_if.sv
// Instruction-fetch and data-memory request/response bundle between core and responder.
interface core_mem_responder_if;
  import pkg_opengpu::*;

  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   imem_valid;

  logic                   dmem_req;
  logic                   dmem_we;
  logic [ADDR_WIDTH-1:0]  dmem_addr;
  logic [DATA_WIDTH-1:0]  dmem_wdata;
  logic [3:0]             dmem_be;
  logic [DATA_WIDTH-1:0]  dmem_rdata;
  logic                   dmem_valid;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  imem_rdata, imem_valid, dmem_rdata, dmem_valid
  );
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output imem_rdata, imem_valid, dmem_rdata, dmem_valid
  );
endinterface

// File: rtl/core_mem_responder_arb.sv
// Two-requester round-robin arbiter; last_grant advances only on an accepted request.
module mem_rr_arbiter
  import pkg_opengpu::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      req_imem,
  input  logic      req_dmem,
  input  logic      accept,
  output mem_port_e grant
);
  mem_port_e last_grant_q, last_grant_d;

  always_comb begin
    grant = PORT_IMEM;
    if (req_imem && req_dmem)
      grant = (last_grant_q == PORT_IMEM) ? PORT_DMEM : PORT_IMEM;
    else if (req_dmem)
      grant = PORT_DMEM;
    last_grant_d = accept ? grant : last_grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= PORT_IMEM;
    else     last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/core_mem_responder.sv
// Fixed-latency responder serving imem/dmem from one word array, with a word preload port.
module core_mem_responder
  import pkg_opengpu::*;
#(
  parameter int MEM_WORDS = 16384,
  parameter int LATENCY   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  core_mem_responder_if.slave          mem,
  input  logic                         ld_we,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]        ld_wdata,
  output logic                         busy,
  output logic                         mem_err
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-3:0] WORDS_LIM = (ADDR_WIDTH-2)'(MEM_WORDS);

  logic [DATA_WIDTH-1:0] ram [MEM_WORDS];

  mem_resp_state_e       state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  mem_port_e             port_q, port_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  oor_q, oor_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ivld_q, ivld_d, dvld_q, dvld_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  mem_port_e             grant;
  logic                  accept, commit;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-3:0] req_word;

  assign accept   = (state_q == MR_IDLE) && (mem.imem_req || mem.dmem_req);
  assign commit   = (state_q == MR_WAIT) && (cnt_q == 4'd0);
  assign req_addr = (grant == PORT_DMEM) ? mem.dmem_addr : mem.imem_addr;
  assign req_word = req_addr[ADDR_WIDTH-1:2];

  mem_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_imem (mem.imem_req),
    .req_dmem (mem.dmem_req),
    .accept   (accept),
    .grant    (grant)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ivld_d  = 1'b0;
    dvld_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      MR_IDLE: if (accept) begin
        state_d = MR_WAIT;
        cnt_d   = 4'(LATENCY - 1);
        port_d  = grant;
        idx_d   = req_word[IDX_W-1:0];
        oor_d   = (req_word >= WORDS_LIM);
        we_d    = (grant == PORT_DMEM) && mem.dmem_we;
        be_d    = mem.dmem_be;
        wdata_d = mem.dmem_wdata;
      end
      MR_WAIT: if (cnt_q == 4'd0) begin
        // Read data is the pre-commit word, captured on the same edge as any write.
        state_d = MR_RESP;
        ivld_d  = (port_q == PORT_IMEM);
        dvld_d  = (port_q == PORT_DMEM);
        err_d   = oor_q;
        rdata_d = (oor_q || we_q) ? '0 : ram[idx_q];
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      MR_RESP: state_d = MR_IDLE;
      default: state_d = MR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MR_IDLE;
      cnt_q   <= '0;
      port_q  <= PORT_IMEM;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      ivld_q  <= 1'b0;
      dvld_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ivld_q  <= ivld_d;
      dvld_q  <= dvld_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Loader assignment comes last so it overrides a same-word dmem commit.
  always_ff @(posedge clk) begin
    if (commit && we_q && !oor_q)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) ram[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
    if (ld_we) ram[ld_addr] <= ld_wdata;
  end

  assign mem.imem_valid = ivld_q;
  assign mem.dmem_valid = dvld_q;
  assign mem.imem_rdata = ivld_q ? INSTR_WIDTH'(rdata_q) : '0;
  assign mem.dmem_rdata = dvld_q ? rdata_q : '0;
  assign mem_err        = err_q;
  assign busy           = (state_q != MR_IDLE);
endmodule

// File: tb/tb_core_mem_responder.sv
// Self-checking bench: directed table, hand sequences and a randomized model comparison.
module tb_core_mem_responder;
  import pkg_opengpu::*;
  localparam int MW  = 16384;
  localparam int LAT = 2;
  localparam int IW  = $clog2(MW);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_mem_responder_if mif();
  core_mem_responder_if mif1();
  logic          ld_we, ld1_we, busy, busy1, mem_err, mem_err1;
  logic [IW-1:0] ld_addr, ld1_addr;
  logic [31:0]   ld_wdata, ld1_wdata;

  core_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem(mif), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .busy(busy), .mem_err(mem_err));

  core_mem_responder #(.MEM_WORDS(MW), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem(mif1), .ld_we(ld1_we), .ld_addr(ld1_addr),
    .ld_wdata(ld1_wdata), .busy(busy1), .mem_err(mem_err1));

  int checks = 0, errors = 0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t        tbl[8];
  logic [31:0] model[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = IW'(idx); ld_wdata = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // One transaction on one port; lat counts negedges from request to the valid cycle.
  task automatic mem_op(input bit dport, input bit we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rd, output bit err, output int lat);
    @(negedge clk);
    if (dport) begin
      mif.dmem_req = 1'b1; mif.dmem_we = we; mif.dmem_addr = addr;
      mif.dmem_be = be; mif.dmem_wdata = wd;
    end else begin
      mif.imem_req = 1'b1; mif.imem_addr = addr;
    end
    lat = -1; rd = '0; err = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check("stray_valid", dport ? mif.imem_valid : mif.dmem_valid, 1'b0);
      if (dport ? mif.dmem_valid : mif.imem_valid) begin
        lat = c;
        rd  = dport ? mif.dmem_rdata : mif.imem_rdata;
        err = mem_err;
        break;
      end
    end
    mif.imem_req = 1'b0; mif.dmem_req = 1'b0;
    mif.dmem_addr = $urandom; mif.imem_addr = $urandom; mif.dmem_wdata = $urandom;
    @(negedge clk);
    check("valid_one_cycle", dport ? mif.dmem_valid : mif.imem_valid, 1'b0);
    check("idle_after_resp", busy, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          err;
    int          lat;

    mif.imem_req = 0; mif.imem_addr = 0; mif.dmem_req = 0; mif.dmem_we = 0;
    mif.dmem_addr = 0; mif.dmem_wdata = 0; mif.dmem_be = 0;
    mif1.imem_req = 0; mif1.imem_addr = 0; mif1.dmem_req = 0; mif1.dmem_we = 0;
    mif1.dmem_addr = 0; mif1.dmem_wdata = 0; mif1.dmem_be = 0;
    ld_we = 0; ld_addr = 0; ld_wdata = 0; ld1_we = 0; ld1_addr = 0; ld1_wdata = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_imem_valid", mif.imem_valid, 0);
    check("rst_dmem_valid", mif.dmem_valid, 0);
    check("rst_imem_rdata", mif.imem_rdata, 0);
    check("rst_dmem_rdata", mif.dmem_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_err", mem_err, 0);
    rst = 1'b0;

    // Fetch timing: valid only on cycle 3, busy on cycles 1..3.
    load(0, 32'h04E00005);
    @(negedge clk);
    check("fetch_busy_pre", busy, 0);
    mif.imem_req = 1'b1; mif.imem_addr = 32'h0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("fetch_busy", busy, (c <= 3) ? 1 : 0);
      check("fetch_valid", mif.imem_valid, (c == 3) ? 1 : 0);
      if (c == 3) begin
        check("fetch_rdata", mif.imem_rdata, 32'h04E00005);
        mif.imem_req = 1'b0;
      end
    end

    // Directed dmem table.
    load(4, 32'h11223344);
    tbl[0] = '{1'b1, 32'h10,        4'b0011, 32'hAABBCCDD, 32'h0,        1'b0};
    tbl[1] = '{1'b0, 32'h10,        4'b1111, 32'h0,        32'h1122CCDD, 1'b0};
    tbl[2] = '{1'b1, 32'h13,        4'b1100, 32'h55667788, 32'h0,        1'b0};
    tbl[3] = '{1'b0, 32'h12,        4'b1111, 32'h0,        32'h5566CCDD, 1'b0};
    tbl[4] = '{1'b0, 32'h0001_0000, 4'b1111, 32'h0,        32'h0,        1'b1};
    tbl[5] = '{1'b1, 32'h0001_0000, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b1};
    tbl[6] = '{1'b0, 32'h0,         4'b1111, 32'h0,        32'h04E00005, 1'b0};
    tbl[7] = '{1'b0, 32'h10,        4'b0000, 32'h0,        32'h5566CCDD, 1'b0};
    for (int i = 0; i < 8; i++) begin
      mem_op(1'b1, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wd, rd, err, lat);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
      check($sformatf("tbl%0d_lat", i), lat, LAT + 1);
    end

    // Tie after reset: dmem first (cycle 3), imem re-accepted and served at cycle 7.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    mif.imem_req = 1'b1; mif.imem_addr = 32'h10;
    mif.dmem_req = 1'b1; mif.dmem_we = 1'b0; mif.dmem_addr = 32'h0; mif.dmem_be = 4'hF;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("tie_dmem_valid", mif.dmem_valid, (c == 3) ? 1 : 0);
      check("tie_imem_valid", mif.imem_valid, (c == 7) ? 1 : 0);
      if (c == 3) begin
        check("tie_dmem_rdata", mif.dmem_rdata, 32'h04E00005);
        mif.dmem_req = 1'b0;
      end
      if (c == 7) begin
        check("tie_imem_rdata", mif.imem_rdata, 32'h5566CCDD);
        mif.imem_req = 1'b0;
      end
    end

    // Reset during WAIT of a write drops it without committing.
    load(0, 32'h0);
    @(negedge clk);
    mif.dmem_req = 1'b1; mif.dmem_we = 1'b1; mif.dmem_addr = 32'h0;
    mif.dmem_be = 4'hF; mif.dmem_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("rstwait_busy_before", busy, 1);
    #1 rst = 1'b1;
    #1 check("rstwait_busy_async", busy, 0);
    @(negedge clk);
    mif.dmem_req = 1'b0; rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstwait_no_dvalid", mif.dmem_valid, 0);
      check("rstwait_no_ivalid", mif.imem_valid, 0);
    end
    mem_op(1'b1, 1'b0, 32'h0, 4'hF, 32'h0, rd, err, lat);
    check("rstwait_word0", rd, 32'h0);
    check("rstwait_lat", lat, LAT + 1);

    // Loader write on the commit edge of a same-word dmem write wins.
    @(negedge clk);
    mif.dmem_req = 1'b1; mif.dmem_we = 1'b1; mif.dmem_addr = 32'h14;
    mif.dmem_be = 4'hF; mif.dmem_wdata = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = IW'(5); ld_wdata = 32'h9ABCDEF0;
    @(negedge clk);
    ld_we = 1'b0;
    check("ldwin_valid", mif.dmem_valid, 1);
    mif.dmem_req = 1'b0;
    @(negedge clk);
    mem_op(1'b1, 1'b0, 32'h14, 4'hF, 32'h0, rd, err, lat);
    check("ldwin_word5", rd, 32'h9ABCDEF0);

    // Randomized traffic against a word-array model.
    for (int w = 0; w < 64; w++) begin
      model[w] = $urandom;
      load(w, model[w]);
    end
    for (int n = 0; n < 60; n++) begin
      bit          dp, we, oor;
      int          w;
      logic [31:0] addr, wd, exp;
      logic [3:0]  be;
      dp  = $urandom_range(0, 1) == 1;
      we  = dp && ($urandom_range(0, 1) == 1);
      oor = $urandom_range(0, 7) == 0;
      w   = oor ? MW + int'($urandom_range(0, 1000)) : int'($urandom_range(0, 63));
      addr = (32'(w) << 2) | 32'($urandom_range(0, 3));
      be  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      exp = (oor || we) ? 32'h0 : model[w % 64];
      mem_op(dp, we, addr, be, wd, rd, err, lat);
      check("rand_rdata", rd, exp);
      check("rand_err", err, oor);
      check("rand_lat", lat, LAT + 1);
      if (we && !oor)
        for (int b = 0; b < 4; b++)
          if (be[b]) model[w][8*b +: 8] = wd[8*b +: 8];
    end
    for (int w = 0; w < 64; w += 9) begin
      mem_op(1'b0, 1'b0, 32'(w) << 2, 4'h0, 32'h0, rd, err, lat);
      check("rand_final", rd, model[w]);
    end

    // LATENCY=1 with a held fetch: pulses on cycles 2,5,8,...
    @(negedge clk);
    ld1_we = 1'b1; ld1_addr = '0; ld1_wdata = 32'hCAFEF00D;
    @(negedge clk);
    ld1_we = 1'b0;
    mif1.imem_req = 1'b1; mif1.imem_addr = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check("hold_valid", mif1.imem_valid, (c >= 2 && (c - 2) % 3 == 0) ? 1 : 0);
      if (mif1.imem_valid) check("hold_rdata", mif1.imem_rdata, 32'hCAFEF00D);
    end
    mif1.imem_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_mem_responder.md
# core_mem_responder

Synthesizable responder for the core's instruction-fetch and data-memory request ports. It serves `imem_*` and `dmem_*` transactions from one internal single-port word array, using round-robin arbitration and a programmable access latency. It sits directly under the core at the top level and is the hardware counterpart of the behavioural memory model used in simulation. A word-wide load port lets the bench or boot logic preload program images.

## Interface
- `MEM_WORDS`, 16384: array depth in 32-bit words (64 KiB).
- `LATENCY`, 2: cycles from accept edge to response edge; legal range 1..15.
- `clk` in 1: single clock; every state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req` in 1: fetch request; held high until `imem_valid`.
- `imem_addr` in ADDR_WIDTH: byte address; bits [1:0] ignored.
- `imem_rdata` out INSTR_WIDTH: fetched word; valid only while `imem_valid`.
- `imem_valid` out 1: one-cycle response strobe.
- `dmem_req` in 1: data request; held high until `dmem_valid`.
- `dmem_we` in 1: 1 = write, 0 = read.
- `dmem_addr` in ADDR_WIDTH: byte address; bits [1:0] ignored.
- `dmem_wdata` in DATA_WIDTH: write data.
- `dmem_be` in 4: byte enables; bit i enables byte lane i.
- `dmem_rdata` out DATA_WIDTH: read data; 0 on write responses.
- `dmem_valid` out 1: one-cycle response strobe.
- `ld_we` in 1: preload write strobe.
- `ld_addr` in $clog2(MEM_WORDS): preload word index.
- `ld_wdata` in DATA_WIDTH: preload data.
- `busy` out 1: high whenever state ≠ IDLE.
- `mem_err` out 1: one-cycle pulse, coincident with valid, when an access is out of range.

## Operation
**States**
- IDLE: accepts requests.
- WAIT: counts latency.
- RESP: drives the response strobe.

**Transitions**
- IDLE → WAIT at any edge where `imem_req | dmem_req` is high.
  - Latch the granted port, word index, we, be and wdata.
  - Load `cnt = LATENCY-1`.
- WAIT: if `cnt == 0`, go to RESP; otherwise decrement `cnt`.
- RESP → IDLE unconditionally.

**Arbitration**
- Only one request pending: grant it.
- Both pending: grant the port not granted last.
- `last_grant` resets to IMEM, so dmem wins the first tie.

**Data**
- Word index is `addr[ADDR_WIDTH-1:2]`. Byte order is little-endian: lane 0 = bits [7:0].
- Read: the RESP-cycle output is the array word as it stood at the WAIT→RESP edge.
- Write: lanes with `be=1` are merged into the array at the WAIT→RESP edge.
- Out of range (index ≥ MEM_WORDS): no array write, rdata = 0, `mem_err` pulses with valid.
- Loader: `ld_we` writes the full word at every edge, in any state. If it hits the same word on the same edge as a dmem commit, the loader wins.

**Outputs**
- Only the granted port's valid is driven, in RESP.
- `rdata` is 0 outside RESP.

**Reset**
- Forces IDLE, `cnt = 0`, `last_grant = IMEM`, and all outputs to 0.
- An in-flight transaction is dropped. If reset occurs before its commit edge, no write happens.
- Array contents are not reset.

## Timing
- Request sampled at accept edge E → valid is high for exactly the cycle between edges E+LATENCY and E+LATENCY+1.
- A requester holding req continuously is re-accepted at edge E+LATENCY+2. One port alone therefore sees one transaction per LATENCY+2 cycles.
- Requesters must sample valid and may drop req in the same cycle. A req still high at the first IDLE edge is a new request.
- Address, we, be and wdata are only required to be stable at the accept edge.

## Structure
- In `pkg_opengpu`:
  - `typedef enum logic [1:0] {MR_IDLE, MR_WAIT, MR_RESP} mem_resp_state_e`
  - `typedef enum logic {PORT_IMEM, PORT_DMEM} mem_port_e`
- Reuse the package's `ADDR_WIDTH`, `DATA_WIDTH` and `INSTR_WIDTH`.
- Optional sub-module `mem_rr_arbiter`: a 2-requester round-robin arbiter with a `last_grant` register, updated on the accept strobe. FSM, counter, array and byte merge stay in the top.

## Test plan
- Preload word 0 = 0x04E00005, LATENCY=2, assert `imem_req` addr 0 before edge E → `imem_valid` high only in cycle E+2..E+3, rdata 0x04E00005, `busy` high E..E+3.
- Word 4 = 0x11223344; dmem write addr 0x10, be 4'b0011, data 0xAABBCCDD → `dmem_valid` one cycle with rdata 0; subsequent read of 0x10 returns 0x1122CCDD.
- After reset, imem and dmem requests both rise before the same edge → dmem served first; imem accepted at the first IDLE edge, LATENCY+2 cycles later.
- dmem read at addr 0x0001_0000 (MEM_WORDS=16384) → `dmem_valid` and `mem_err` pulse together with rdata 0. A write to the same address leaves every word unchanged.
- Reset pulsed mid-WAIT of a dmem write to word 0 (initially 0) → no valid strobes, `busy` drops asynchronously, word 0 still 0, next request serviced normally.
- `imem_req` held high for 20 cycles, LATENCY=1 → `imem_valid` pulses every 3 cycles, never on adjacent cycles.
